exers_age_rs: RTL and testbench



---
 rtl/exers_age_rs_if.sv | 53 +++++
 rtl/exers_age_rs.sv | 154 +++++++++++++++
 tb/tb_exers_age_rs.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/exers_age_rs_if.sv
// rtl/exers_age_rs_if.sv - rename/issue/writeback bus of the age-ordered reservation station
interface exers_age_rs_if #(
   parameter int RS_ENTRIES = 16,
   parameter int WB_PORTS   = 2,
   parameter int NUM_SC     = 2,
   parameter int NUM_MC     = 2,
   parameter int ROBID_W    = 7
);
   logic                          rename_exers_write;
   logic [4:0]                    rename_op;
   logic [ROBID_W-1:0]            rename_robid;
   logic [5:0]                    rename_rd;
   logic                          rename_op1ready;
   logic                          rename_op2ready;
   logic [31:0]                   rename_op1;
   logic [31:0]                   rename_op2;
   logic                          exers_stall;
   logic [$clog2(RS_ENTRIES):0]   exers_free;
   logic [ROBID_W-1:0]            exers_robid;
   logic [5:0]                    exers_rd;
   logic [31:0]                   exers_op1;
   logic [31:0]                   exers_op2;
   logic [4:0]                    exers_scalu_op;
   logic [4:0]                    exers_mcalu_op;
   logic [NUM_SC-1:0]             exers_scalu_issue;
   logic [NUM_MC-1:0]             exers_mcalu_issue;
   logic [NUM_SC-1:0]             scalu_stall;
   logic [NUM_MC-1:0]             mcalu_stall;
   logic [WB_PORTS-1:0]           wb_valid;
   logic [WB_PORTS-1:0]           wb_error;
   logic [WB_PORTS*ROBID_W-1:0]   wb_robid;
   logic [WB_PORTS*6-1:0]         wb_rd;
   logic [WB_PORTS*32-1:0]        wb_result;
   logic                          rob_flush;

   modport master (
      output rename_exers_write, rename_op, rename_robid, rename_rd,
             rename_op1ready, rename_op2ready, rename_op1, rename_op2,
             scalu_stall, mcalu_stall, wb_valid, wb_error, wb_robid, wb_rd,
             wb_result, rob_flush,
      input  exers_stall, exers_free, exers_robid, exers_rd, exers_op1, exers_op2,
             exers_scalu_op, exers_mcalu_op, exers_scalu_issue, exers_mcalu_issue
   );

   modport slave (
      input  rename_exers_write, rename_op, rename_robid, rename_rd,
             rename_op1ready, rename_op2ready, rename_op1, rename_op2,
             scalu_stall, mcalu_stall, wb_valid, wb_error, wb_robid, wb_rd,
             wb_result, rob_flush,
      output exers_stall, exers_free, exers_robid, exers_rd, exers_op1, exers_op2,
             exers_scalu_op, exers_mcalu_op, exers_scalu_issue, exers_mcalu_issue
   );
endinterface

// File: rtl/exers_age_rs.sv
// rtl/exers_age_rs.sv - reservation station with age-matrix oldest-first issue to scalu/mcalu
module exers_age_rs #(
   parameter int RS_ENTRIES = 16,
   parameter int WB_PORTS   = 2,
   parameter int NUM_SC     = 2,
   parameter int NUM_MC     = 2,
   parameter int ROBID_W    = 7
) (
   input  logic            clk,
   input  logic            rst,
   exers_age_rs_if.slave   bus
);
   localparam int IW = $clog2(RS_ENTRIES);
   localparam int FW = IW + 1;

   logic [RS_ENTRIES-1:0] valid, r1, r2, elig, iss_oh;
   logic [RS_ENTRIES-1:0] age [RS_ENTRIES];
   logic [4:0]            e_op    [RS_ENTRIES];
   logic [ROBID_W-1:0]    e_robid [RS_ENTRIES];
   logic [5:0]            e_rd    [RS_ENTRIES];
   logic [31:0]           e_op1   [RS_ENTRIES];
   logic [31:0]           e_op2   [RS_ENTRIES];
   logic [32:0]           w1 [RS_ENTRIES];
   logic [32:0]           w2 [RS_ENTRIES];
   logic [32:0]           wi1, wi2;
   logic [FW-1:0]         free_q;
   logic [WB_PORTS-1:0]   resolving;
   logic [IW-1:0]         ins_idx, sel;
   logic                  ins, iss, sc_any, mc_any, sel_mc;
   logic                  unused_wb_rd;

   // {hit, result}; scanning downward lets the lowest matching port win
   function automatic logic [32:0] wake(input logic [ROBID_W-1:0] tag,
                                        input logic [WB_PORTS-1:0] res,
                                        input logic [WB_PORTS*ROBID_W-1:0] robids,
                                        input logic [WB_PORTS*32-1:0] results);
      wake = '0;
      for (int p = WB_PORTS - 1; p >= 0; p--)
         if (res[p] && robids[p*ROBID_W +: ROBID_W] == tag)
            wake = {1'b1, results[p*32 +: 32]};
   endfunction

   assign unused_wb_rd = ^bus.wb_rd;

   always_comb begin
      for (int p = 0; p < WB_PORTS; p++)
         resolving[p] = bus.wb_valid[p] & ~bus.wb_error[p] & ~bus.wb_rd[p*6+5];
   end

   always_comb begin
      wi1 = wake(bus.rename_op1[ROBID_W-1:0], resolving, bus.wb_robid, bus.wb_result);
      wi2 = wake(bus.rename_op2[ROBID_W-1:0], resolving, bus.wb_robid, bus.wb_result);
      for (int i = 0; i < RS_ENTRIES; i++) begin
         w1[i] = wake(e_op1[i][ROBID_W-1:0], resolving, bus.wb_robid, bus.wb_result);
         w2[i] = wake(e_op2[i][ROBID_W-1:0], resolving, bus.wb_robid, bus.wb_result);
      end
   end

   assign bus.exers_stall = (free_q == '0);
   assign bus.exers_free  = free_q;
   assign ins    = bus.rename_exers_write & ~bus.exers_stall & ~bus.rob_flush;
   assign sc_any = |(~bus.scalu_stall);
   assign mc_any = |(~bus.mcalu_stall);

   always_comb begin
      ins_idx = '0;
      for (int i = RS_ENTRIES - 1; i >= 0; i--)
         if (!valid[i]) ins_idx = IW'(i);
   end

   always_comb begin
      for (int i = 0; i < RS_ENTRIES; i++)
         elig[i] = valid[i] & r1[i] & r2[i] & ~bus.rob_flush &
                   ((e_op[i][4:3] == 2'b11) ? mc_any : (mc_any | sc_any));
   end

   // the oldest eligible entry is the only one with no older eligible entry
   always_comb begin
      sel = '0;
      iss = 1'b0;
      for (int i = 0; i < RS_ENTRIES; i++)
         if (elig[i] && ((age[i] & elig) == '0)) begin
            sel = IW'(i);
            iss = 1'b1;
         end
      iss_oh = iss ? (RS_ENTRIES'(1) << sel) : '0;
   end

   assign sel_mc = (e_op[sel][4:3] == 2'b11);

   // sc ops prefer scalus so mcalus stay open for mc-only work
   always_comb begin
      bus.exers_scalu_issue = '0;
      bus.exers_mcalu_issue = '0;
      if (iss) begin
         if (!sel_mc && sc_any) begin
            for (int u = NUM_SC - 1; u >= 0; u--)
               if (!bus.scalu_stall[u]) bus.exers_scalu_issue = NUM_SC'(1) << u;
         end else begin
            for (int u = NUM_MC - 1; u >= 0; u--)
               if (!bus.mcalu_stall[u]) bus.exers_mcalu_issue = NUM_MC'(1) << u;
         end
      end
   end

   assign bus.exers_robid    = e_robid[sel];
   assign bus.exers_rd       = e_rd[sel];
   assign bus.exers_op1      = e_op1[sel];
   assign bus.exers_op2      = e_op2[sel];
   assign bus.exers_scalu_op = e_op[sel];
   assign bus.exers_mcalu_op = e_op[sel];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid  <= '0;
         free_q <= FW'(RS_ENTRIES);
         for (int i = 0; i < RS_ENTRIES; i++) age[i] <= '0;
      end else if (bus.rob_flush) begin
         valid  <= '0;
         free_q <= FW'(RS_ENTRIES);
         for (int i = 0; i < RS_ENTRIES; i++) age[i] <= '0;
      end else begin
         valid  <= (valid & ~iss_oh) | (ins ? (RS_ENTRIES'(1) << ins_idx) : '0);
         free_q <= free_q + FW'(iss) - FW'(ins);
         for (int i = 0; i < RS_ENTRIES; i++) begin
            if (ins && ins_idx == IW'(i)) age[i] <= valid & ~iss_oh;
            else                          age[i] <= age[i] & ~iss_oh;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < RS_ENTRIES; i++) begin
         if (ins && ins_idx == IW'(i)) begin
            e_op[i]    <= bus.rename_op;
            e_robid[i] <= bus.rename_robid;
            e_rd[i]    <= bus.rename_rd;
            r1[i]      <= bus.rename_op1ready | wi1[32];
            r2[i]      <= bus.rename_op2ready | wi2[32];
            e_op1[i]   <= (!bus.rename_op1ready && wi1[32]) ? wi1[31:0] : bus.rename_op1;
            e_op2[i]   <= (!bus.rename_op2ready && wi2[32]) ? wi2[31:0] : bus.rename_op2;
         end else if (valid[i] && !bus.rob_flush) begin
            if (!r1[i] && w1[i][32]) begin
               e_op1[i] <= w1[i][31:0];
               r1[i]    <= 1'b1;
            end
            if (!r2[i] && w2[i][32]) begin
               e_op2[i] <= w2[i][31:0];
               r2[i]    <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_exers_age_rs.sv
// tb/tb_exers_age_rs.sv - directed self-checking bench for exers_age_rs
module tb_exers_age_rs;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   exers_age_rs_if bus ();
   exers_age_rs dut (.clk(clk), .rst(rst), .bus(bus.slave));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ins(input logic [4:0] op, input logic [6:0] robid,
                      input logic rdy1, input logic [31:0] v1,
                      input logic rdy2, input logic [31:0] v2);
      bus.rename_exers_write = 1'b1;
      bus.rename_op          = op;
      bus.rename_robid       = robid;
      bus.rename_rd          = 6'h03;
      bus.rename_op1ready    = rdy1;
      bus.rename_op1         = v1;
      bus.rename_op2ready    = rdy2;
      bus.rename_op2         = v2;
   endtask

   task automatic wb(input int p, input logic [6:0] robid, input logic [5:0] rd,
                     input logic err, input logic [31:0] res);
      bus.wb_valid[p]          = 1'b1;
      bus.wb_error[p]          = err;
      bus.wb_robid[p*7 +: 7]   = robid;
      bus.wb_rd[p*6 +: 6]      = rd;
      bus.wb_result[p*32 +: 32] = res;
   endtask

   task automatic quiet();
      bus.rename_exers_write = 1'b0;
      bus.wb_valid           = '0;
      bus.wb_error           = '0;
      bus.rob_flush          = 1'b0;
   endtask

   task automatic units(input logic [1:0] sc, input logic [1:0] mc);
      bus.scalu_stall = sc;
      bus.mcalu_stall = mc;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout got running expected finished");
      $fatal(1);
   end

   initial begin
      quiet();
      units(2'b00, 2'b00);
      bus.wb_robid = '0; bus.wb_rd = '0; bus.wb_result = '0;
      ins(5'h01, 7'h01, 1'b1, 32'h1, 1'b1, 32'h2);

      // reset held across an insert
      step(); step();
      check("rst_free", 64'(bus.exers_free), 64'd16);
      check("rst_stall", 64'(bus.exers_stall), 64'd0);
      check("rst_sc", 64'(bus.exers_scalu_issue), 64'd0);
      check("rst_mc", 64'(bus.exers_mcalu_issue), 64'd0);
      rst = 1'b1;
      #1;
      step();
      bus.rename_exers_write = 1'b0;
      #1;
      check("first_sc", 64'(bus.exers_scalu_issue), 64'b01);
      check("first_robid", 64'(bus.exers_robid), 64'h01);
      check("first_free", 64'(bus.exers_free), 64'd15);
      step();
      check("first_free_back", 64'(bus.exers_free), 64'd16);
      check("first_idle", 64'(bus.exers_scalu_issue), 64'd0);

      // age ordering: A waits, B and C ready, D refills B's slot
      units(2'b11, 2'b11);
      ins(5'h01, 7'h01, 1'b0, 32'h10, 1'b1, 32'h0); step();
      ins(5'h01, 7'h02, 1'b1, 32'hB, 1'b1, 32'h0);  step();
      ins(5'h01, 7'h03, 1'b1, 32'hC, 1'b1, 32'h0);  step();
      bus.rename_exers_write = 1'b0;
      #1;
      check("age_free", 64'(bus.exers_free), 64'd13);
      check("age_held", 64'(bus.exers_scalu_issue), 64'd0);
      units(2'b00, 2'b00);
      #1;
      check("age_b", 64'(bus.exers_robid), 64'h02);
      check("age_b_sc", 64'(bus.exers_scalu_issue), 64'b01);
      step();
      check("age_c", 64'(bus.exers_robid), 64'h03);
      step();
      units(2'b11, 2'b11);
      ins(5'h01, 7'h04, 1'b1, 32'hD, 1'b1, 32'h0);
      wb(0, 7'h10, 6'h01, 1'b0, 32'hAAAA5555);
      step();
      quiet();
      units(2'b00, 2'b00);
      #1;
      check("age_a", 64'(bus.exers_robid), 64'h01);
      check("age_a_op1", 64'(bus.exers_op1), 64'hAAAA5555);
      step();
      check("age_d", 64'(bus.exers_robid), 64'h04);
      step();
      check("age_free_back", 64'(bus.exers_free), 64'd16);

      // class-aware arbitration
      units(2'b11, 2'b11);
      ins(5'b11000, 7'h10, 1'b1, 32'h0, 1'b1, 32'h0); step();
      ins(5'b11000, 7'h11, 1'b1, 32'h0, 1'b1, 32'h0); step();
      ins(5'b00001, 7'h12, 1'b1, 32'h0, 1'b1, 32'h0); step();
      bus.rename_exers_write = 1'b0;
      units(2'b00, 2'b01);
      #1;
      check("cls_m1_mc", 64'(bus.exers_mcalu_issue), 64'b10);
      check("cls_m1_sc", 64'(bus.exers_scalu_issue), 64'b00);
      check("cls_m1_robid", 64'(bus.exers_robid), 64'h10);
      check("cls_m1_op", 64'(bus.exers_mcalu_op), 64'b11000);
      step();
      check("cls_m2_mc", 64'(bus.exers_mcalu_issue), 64'b10);
      check("cls_m2_robid", 64'(bus.exers_robid), 64'h11);
      step();
      check("cls_s_sc", 64'(bus.exers_scalu_issue), 64'b01);
      check("cls_s_mc", 64'(bus.exers_mcalu_issue), 64'b00);
      check("cls_s_robid", 64'(bus.exers_robid), 64'h12);
      step();
      units(2'b11, 2'b10);
      ins(5'b00001, 7'h13, 1'b1, 32'h0, 1'b1, 32'h0); step();
      bus.rename_exers_write = 1'b0;
      #1;
      check("cls_spill_mc", 64'(bus.exers_mcalu_issue), 64'b01);
      check("cls_spill_sc", 64'(bus.exers_scalu_issue), 64'b00);
      step();
      units(2'b00, 2'b00);

      // operand woken in its insert cycle, lowest port wins on double match
      ins(5'h01, 7'h20, 1'b0, 32'h22, 1'b1, 32'h5);
      wb(1, 7'h22, 6'h02, 1'b0, 32'hDEADBEEF);
      step();
      quiet();
      #1;
      check("iwk_op1", 64'(bus.exers_op1), 64'hDEADBEEF);
      check("iwk_op2", 64'(bus.exers_op2), 64'h5);
      check("iwk_sc", 64'(bus.exers_scalu_issue), 64'b01);
      step();
      ins(5'h01, 7'h21, 1'b0, 32'h23, 1'b1, 32'h6);
      wb(0, 7'h23, 6'h02, 1'b0, 32'h111);
      wb(1, 7'h23, 6'h02, 1'b0, 32'h222);
      step();
      quiet();
      #1;
      check("iwk_lowport", 64'(bus.exers_op1), 64'h111);
      step();

      // error and rd[5] writebacks do not wake
      ins(5'h01, 7'h30, 1'b0, 32'h31, 1'b1, 32'h7); step();
      bus.rename_exers_write = 1'b0;
      #1;
      check("flt_wait", 64'(bus.exers_scalu_issue), 64'd0);
      check("flt_free", 64'(bus.exers_free), 64'd15);
      wb(0, 7'h31, 6'h01, 1'b1, 32'h55); step(); quiet(); #1;
      check("flt_err", 64'(bus.exers_scalu_issue), 64'd0);
      wb(0, 7'h31, 6'h21, 1'b0, 32'h66); step(); quiet(); #1;
      check("flt_rd5", 64'(bus.exers_scalu_issue), 64'd0);
      wb(0, 7'h31, 6'h01, 1'b0, 32'h77); step(); quiet(); #1;
      check("flt_ok_sc", 64'(bus.exers_scalu_issue), 64'b01);
      check("flt_ok_op1", 64'(bus.exers_op1), 64'h77);
      step();

      // full, simultaneous issue+insert, flush
      units(2'b11, 2'b11);
      for (int i = 0; i < 16; i++) begin
         ins(5'h01, 7'(8'h40 + i), 1'b1, 32'h0, 1'b1, 32'h0);
         step();
      end
      bus.rename_exers_write = 1'b0;
      #1;
      check("full_stall", 64'(bus.exers_stall), 64'd1);
      check("full_free", 64'(bus.exers_free), 64'd0);
      ins(5'h01, 7'h7F, 1'b1, 32'h0, 1'b1, 32'h0); step();
      bus.rename_exers_write = 1'b0;
      #1;
      check("full_drop", 64'(bus.exers_free), 64'd0);
      units(2'b00, 2'b00);
      #1;
      check("full_oldest", 64'(bus.exers_robid), 64'h40);
      step();
      check("full_free1", 64'(bus.exers_free), 64'd1);
      ins(5'h01, 7'h7E, 1'b1, 32'h0, 1'b1, 32'h0);
      #1;
      check("both_robid", 64'(bus.exers_robid), 64'h41);
      step();
      bus.rename_exers_write = 1'b0;
      #1;
      check("both_free", 64'(bus.exers_free), 64'd1);
      bus.rob_flush = 1'b1;
      ins(5'h01, 7'h7D, 1'b1, 32'h0, 1'b1, 32'h0);
      #1;
      check("flush_sc", 64'(bus.exers_scalu_issue), 64'd0);
      check("flush_mc", 64'(bus.exers_mcalu_issue), 64'd0);
      step();
      quiet();
      #1;
      check("flush_free", 64'(bus.exers_free), 64'd16);
      check("flush_idle", 64'(bus.exers_scalu_issue), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
